// File: rtl/cm_loop_sched.sv
// Three-deep loop-nest index generator: walks (idx0,idx1,idx2) from (0,0,0) up to latched bounds.
// Latency: tuple (0,0,0) valid on the edge after an accepted start; one step per handshake.
// Backpressure: I_ready=0 holds the tuple and flags; I_abort cancels a nest; done pulses once at the end.
//
// Ports:
//   I_clk, I_rst          clock, synchronous active-high reset
//   I_start, I_abort      begin a nest (IDLE only) / cancel the running nest
//   I_upper0..2           inclusive bounds of inner, middle and outer loops (sampled at start)
//   I_ready               downstream accepts the current tuple
//   O_valid, O_idx0..2    current index tuple
//   O_first, O_last       tuple is (0,0,0) / tuple equals latched bounds (both qualified by O_valid)
//   O_busy, O_done        nest in progress / one-cycle completion pulse
module cm_loop_sched #(
  parameter int C_WIDTH = 8
) (
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic               I_start,
  input  logic               I_abort,
  input  logic [C_WIDTH-1:0] I_upper0,
  input  logic [C_WIDTH-1:0] I_upper1,
  input  logic [C_WIDTH-1:0] I_upper2,
  input  logic               I_ready,
  output logic               O_valid,
  output logic [C_WIDTH-1:0] O_idx0,
  output logic [C_WIDTH-1:0] O_idx1,
  output logic [C_WIDTH-1:0] O_idx2,
  output logic               O_first,
  output logic               O_last,
  output logic               O_busy,
  output logic               O_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [C_WIDTH-1:0] idx0_q, idx1_q, idx2_q;
  logic [C_WIDTH-1:0] idx0_d, idx1_d, idx2_d;
  logic [C_WIDTH-1:0] up0_q, up1_q, up2_q;
  logic [C_WIDTH-1:0] up0_d, up1_d, up2_d;

  // Per-loop wrap conditions: compared against the latched bound so that an
  // all-ones bound wraps cleanly instead of relying on natural overflow.
  logic wrap0, wrap1, wrap2, at_last, handshake;

  assign wrap0     = (idx0_q == up0_q);
  assign wrap1     = (idx1_q == up1_q);
  assign wrap2     = (idx2_q == up2_q);
  assign at_last   = wrap0 & wrap1 & wrap2;
  assign handshake = (state_q == S_RUN) & I_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (I_start) state_d = S_RUN;
      S_RUN: begin
        // Abort wins over a handshake presented in the same cycle.
        if (I_abort)                  state_d = S_IDLE;
        else if (handshake && at_last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    O_valid = 1'b0;
    O_busy  = 1'b0;
    O_done  = 1'b0;
    O_first = 1'b0;
    O_last  = 1'b0;
    case (state_q)
      S_RUN: begin
        O_valid = 1'b1;
        O_busy  = 1'b1;
        O_first = (idx0_q == '0) && (idx1_q == '0) && (idx2_q == '0);
        O_last  = at_last;
      end
      S_DONE:  O_done = 1'b1;
      default: ;
    endcase
  end

  assign O_idx0 = idx0_q;
  assign O_idx1 = idx1_q;
  assign O_idx2 = idx2_q;

  // ---------------- index / bound datapath ----------------
  always_comb begin
    idx0_d = idx0_q;
    idx1_d = idx1_q;
    idx2_d = idx2_q;
    up0_d  = up0_q;
    up1_d  = up1_q;
    up2_d  = up2_q;
    if (state_q == S_IDLE) begin
      if (I_start) begin
        up0_d  = I_upper0;
        up1_d  = I_upper1;
        up2_d  = I_upper2;
        idx0_d = '0;
        idx1_d = '0;
        idx2_d = '0;
      end
    end else if (state_q == S_RUN) begin
      if (I_abort) begin
        idx0_d = '0;
        idx1_d = '0;
        idx2_d = '0;
      end else if (I_ready) begin
        // Ripple carry inner -> outer. The final step wraps every index to 0,
        // which leaves the indices cleared for DONE and the following IDLE.
        idx0_d = wrap0 ? '0 : idx0_q + C_WIDTH'(1);
        if (wrap0) begin
          idx1_d = wrap1 ? '0 : idx1_q + C_WIDTH'(1);
          if (wrap1) begin
            idx2_d = wrap2 ? '0 : idx2_q + C_WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      idx0_q <= '0;
      idx1_q <= '0;
      idx2_q <= '0;
      up0_q  <= '0;
      up1_q  <= '0;
      up2_q  <= '0;
    end else begin
      idx0_q <= idx0_d;
      idx1_q <= idx1_d;
      idx2_q <= idx2_d;
      up0_q  <= up0_d;
      up1_q  <= up1_d;
      up2_q  <= up2_d;
    end
  end

endmodule

// File: tb/tb_cm_loop_sched.sv
// Bench for cm_loop_sched: directed nests with randomized ready/upper-bound noise,
// each beat compared against a tuple computed arithmetically from the beat number.
module tb_cm_loop_sched;

  localparam int W = 8;

  logic         I_clk = 1'b0;
  logic         I_rst, I_start, I_abort, I_ready;
  logic [W-1:0] I_upper0, I_upper1, I_upper2;
  logic         O_valid, O_first, O_last, O_busy, O_done;
  logic [W-1:0] O_idx0, O_idx1, O_idx2;

  int tests = 0;
  int fails = 0;

  cm_loop_sched #(.C_WIDTH(W)) dut (
    .I_clk   (I_clk),
    .I_rst   (I_rst),
    .I_start (I_start),
    .I_abort (I_abort),
    .I_upper0(I_upper0),
    .I_upper1(I_upper1),
    .I_upper2(I_upper2),
    .I_ready (I_ready),
    .O_valid (O_valid),
    .O_idx0  (O_idx0),
    .O_idx1  (O_idx1),
    .O_idx2  (O_idx2),
    .O_first (O_first),
    .O_last  (O_last),
    .O_busy  (O_busy),
    .O_done  (O_done)
  );

  initial forever #5 I_clk = ~I_clk;

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, 32'(O_valid), 0);
    check({tag, ".busy"},  32'(O_busy),  0);
    check({tag, ".done"},  32'(O_done),  0);
    check({tag, ".first"}, 32'(O_first), 0);
    check({tag, ".last"},  32'(O_last),  0);
    check({tag, ".idx0"},  32'(O_idx0),  0);
    check({tag, ".idx1"},  32'(O_idx1),  0);
    check({tag, ".idx2"},  32'(O_idx2),  0);
  endtask

  // Runs one nest. pct = I_ready probability in percent. scramble = wiggle
  // I_upper during the run. poke = drive I_start in RUN (random) and in DONE
  // (with I_abort). cut_at >= 0 interrupts at that beat with abort or reset.
  task automatic run_nest(input string name, input int u0, input int u1, input int u2,
                          input int pct, input bit scramble, input bit poke,
                          input int cut_at, input bit cut_rst);
    int total, k, cycles, budget, e0, e1, e2;
    bit rdy;
    total  = (u0 + 1) * (u1 + 1) * (u2 + 1);
    budget = total * 25 + 20;
    k      = 0;
    cycles = 0;
    I_upper0 = W'(u0);
    I_upper1 = W'(u1);
    I_upper2 = W'(u2);
    I_start  = 1'b1;
    tick();
    I_start = 1'b0;
    while (k < total && cycles < budget) begin
      // Expected tuple is the mixed-radix digits of the beat number.
      e0 = k % (u0 + 1);
      e1 = (k / (u0 + 1)) % (u1 + 1);
      e2 = k / ((u0 + 1) * (u1 + 1));
      check({name, ".valid"}, 32'(O_valid), 1);
      check({name, ".busy"},  32'(O_busy),  1);
      check({name, ".done"},  32'(O_done),  0);
      check({name, ".idx0"},  32'(O_idx0),  32'(e0));
      check({name, ".idx1"},  32'(O_idx1),  32'(e1));
      check({name, ".idx2"},  32'(O_idx2),  32'(e2));
      check({name, ".first"}, 32'(O_first), (k == 0) ? 1 : 0);
      check({name, ".last"},  32'(O_last),  (k == total - 1) ? 1 : 0);
      if (k == cut_at) begin
        I_ready = 1'b1;
        if (cut_rst) begin
          I_rst   = 1'b1;
          I_start = 1'b1;
        end else begin
          I_abort = 1'b1;
        end
        tick();
        I_rst   = 1'b0;
        I_abort = 1'b0;
        I_start = 1'b0;
        check_idle({name, ".cut"});
        tick();
        check_idle({name, ".cut2"});
        return;
      end
      if (scramble) begin
        I_upper0 = W'($urandom_range(255));
        I_upper1 = W'($urandom_range(255));
        I_upper2 = W'($urandom_range(255));
      end
      if (poke) I_start = 1'($urandom_range(1));
      rdy     = ($urandom_range(99) < pct);
      I_ready = rdy;
      tick();
      cycles++;
      if (rdy) k++;
    end
    I_start = 1'b0;
    check({name, ".beats"}, 32'(k), 32'(total));
    check({name, ".done_pulse"}, 32'(O_done), 1);
    check({name, ".done_valid"}, 32'(O_valid), 0);
    check({name, ".done_busy"},  32'(O_busy),  0);
    check({name, ".done_first"}, 32'(O_first), 0);
    check({name, ".done_last"},  32'(O_last),  0);
    if (poke) begin
      I_start = 1'b1;
      I_abort = 1'b1;
    end
    tick();
    I_start = 1'b0;
    I_abort = 1'b0;
    check_idle({name, ".idle"});
    tick();
    check_idle({name, ".idle2"});
  endtask

  initial begin
    I_rst    = 1'b1;
    I_start  = 1'b0;
    I_abort  = 1'b0;
    I_ready  = 1'b0;
    I_upper0 = '0;
    I_upper1 = '0;
    I_upper2 = '0;
    tick();
    tick();
    check_idle("reset");
    I_rst = 1'b0;
    tick();
    check_idle("post_reset");

    // Abort while idle must not start anything.
    I_abort = 1'b1;
    tick();
    I_abort = 1'b0;
    check_idle("abort_idle");

    run_nest("basic",        2, 1, 1, 100, 1'b0, 1'b0, -1, 1'b0);
    run_nest("single",       0, 0, 0, 100, 1'b0, 1'b0, -1, 1'b0);
    run_nest("hold_a",       3, 0, 0,  50, 1'b1, 1'b0, -1, 1'b0);
    run_nest("hold_b",       3, 0, 0,  30, 1'b1, 1'b0, -1, 1'b0);
    run_nest("abort",        3, 3, 0, 100, 1'b0, 1'b0,  4, 1'b0);
    run_nest("after_abort",  3, 3, 0,  60, 1'b0, 1'b0, -1, 1'b0);
    run_nest("ignore_start", 2, 2, 1,  70, 1'b0, 1'b1, -1, 1'b0);
    run_nest("reset_mid",    2, 1, 1, 100, 1'b0, 1'b0,  2, 1'b1);
    run_nest("after_reset",  2, 1, 1, 100, 1'b0, 1'b0, -1, 1'b0);
    run_nest("all_ones",   255, 0, 0, 100, 1'b0, 1'b0, -1, 1'b0);
    run_nest("wide",       255, 1, 1,  80, 1'b1, 1'b1, -1, 1'b0);
    run_nest("outer",        0, 2, 4,  50, 1'b1, 1'b0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
